// File: rtl/mips_register_file.sv
// MIPS general-purpose register file: one synchronous write port, two combinational reads.
// Register 0 is hardwired to zero; define REGFILE_BYPASS_EN for write-to-read forwarding.
module mips_register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   output logic [DATA_WIDTH-1:0] rdata1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata2
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr_ok;

   assign wr_ok = we && !reset && (waddr != '0);

   // Clear everything on reset; otherwise commit one write, never to r0.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[waddr] <= wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Port 1 read, forwarding a same-cycle write so decode sees it without a stall.
   always_comb begin
      rdata1 = '0;
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (wr_ok && (raddr1 == waddr)) begin
         rdata1 = wdata;
      end else begin
         rdata1 = mem[raddr1];
      end
   end

   // Port 2 read, with the same forwarding path as port 1.
   always_comb begin
      rdata2 = '0;
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (wr_ok && (raddr2 == waddr)) begin
         rdata2 = wdata;
      end else begin
         rdata2 = mem[raddr2];
      end
   end
`else
   // Port 1 read straight from storage; r0 forced to zero.
   always_comb begin
      rdata1 = '0;
      if (raddr1 != '0) begin
         rdata1 = mem[raddr1];
      end
   end

   // Port 2 read straight from storage; r0 forced to zero.
   always_comb begin
      rdata2 = '0;
      if (raddr2 != '0) begin
         rdata2 = mem[raddr2];
      end
   end
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file with a queue scoreboard of expected read data.
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN.
module tb_mips_register_file;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;

   int checks;
   int errors;
   logic [31:0] sb_q[$];

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   mips_register_file #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .we(we),
      .waddr(waddr),
      .wdata(wdata),
      .raddr1(raddr1),
      .rdata1(rdata1),
      .raddr2(raddr2),
      .rdata2(rdata2)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sweep_val(input int i);
      logic [31:0] v;
      v = 32'(i) * 32'h0101_0101;
      return v;
   endfunction

   task automatic check(input string tag, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [31:0] e1,
                        input logic [31:0] e2);
      logic [31:0] x1;
      logic [31:0] x2;
      raddr1 = a1;
      raddr2 = a2;
      sb_q.push_back(e1);
      sb_q.push_back(e2);
      #1;
      x1 = sb_q.pop_front();
      x2 = sb_q.pop_front();
      checks++;
      assert (rdata1 === x1) else begin
         errors++;
         $error("FAIL %s rd1 addr=%0d got=%h exp=%h", tag, a1, rdata1, x1);
      end
      checks++;
      assert (rdata2 === x2) else begin
         errors++;
         $error("FAIL %s rd2 addr=%0d got=%h exp=%h", tag, a2, rdata2, x2);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      we     = 1'b0;
      waddr  = '0;
      wdata  = '0;
      raddr1 = '0;
      raddr2 = '0;

      // reset then sweep all addresses
      step();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check("reset_sweep", 5'(i), 5'(31 - i), 32'h0, 32'h0);
      end

      // basic write/read
      step();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
      step();
      we = 1'b0;
      check("wr5", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      check("rd6", 5'd6, 5'd5, 32'h0, 32'hDEAD_BEEF);

      // write to r0 is discarded, no forwarding either
      step();
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
      check("r0_during", 5'd0, 5'd0, 32'h0, 32'h0);
      step();
      we = 1'b0;
      check("r0_after", 5'd0, 5'd0, 32'h0, 32'h0);

      // reset beats write; reads before the edge still show storage
      step();
      reset = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
      check("rst_pre", 5'd7, 5'd5, 32'h0, 32'hDEAD_BEEF);
      step();
      reset = 1'b0; we = 1'b0;
      check("rst_post", 5'd7, 5'd5, 32'h0, 32'h0);

      // same-cycle read of the register being written
      step();
      we = 1'b1; waddr = 5'd9; wdata = 32'h1111_1111;
      step();
      wdata = 32'h2222_2222;
      check("same_cyc", 5'd9, 5'd9,
            BYP ? 32'h2222_2222 : 32'h1111_1111,
            BYP ? 32'h2222_2222 : 32'h1111_1111);
      step();
      we = 1'b0;
      check("same_post", 5'd9, 5'd9, 32'h2222_2222, 32'h2222_2222);

      // write in the cycle reset drops takes effect
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
      step();
      we = 1'b0;
      check("rst_release", 5'd3, 5'd9, 32'hA5A5_A5A5, 32'h0);

      // full sweep of writes on consecutive edges
      for (int i = 1; i < 32; i++) begin
         we = 1'b1; waddr = 5'(i); wdata = sweep_val(i);
         step();
      end
      we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check("full_sweep", 5'(i), 5'(31 - i), sweep_val(i), sweep_val(31 - i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
